vga_fb_arbiter: RTL and testbench

VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

---
 rtl/vga_fb_arbiter.sv | 154 +++++++++++++++
 tb/tb_vga_fb_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: display reads take priority over hardware fills
// and CPU block writes. The output is a fixed two-cycle pixel pipeline into the VGA stage.
module vga_fb_arbiter #(
    parameter int FB_W = 160,
    parameter int FB_H = 120
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  h_addr,
    input  logic [9:0]  v_addr,
    input  logic        vga_valid,
    output logic [11:0] vga_data,
    input  logic        cpu_valid,
    output logic        cpu_ready,
    input  logic [7:0]  cpu_x,
    input  logic [6:0]  cpu_y,
    input  logic [11:0] cpu_color,
    input  logic        clr_start,
    input  logic [11:0] clr_color,
    output logic        clr_busy,
    output logic        clr_done,
    output logic [14:0] ram_addr,
    output logic        ram_we,
    output logic [11:0] ram_wdata,
    input  logic [11:0] ram_rdata
);

    localparam logic [14:0] LAST_ADDR = 15'(FB_W * FB_H - 1);
    localparam logic [8:0]  FB_W_9    = 9'(FB_W);
    localparam logic [7:0]  FB_H_8    = 8'(FB_H);

    typedef enum logic {
        ST_IDLE,
        ST_FILL
    } state_e;

    // Constant multiply by FB_W as a sum of shifted copies (160 -> <<7 plus <<5).
    function automatic logic [14:0] mul_fb_w(input logic [14:0] row);
        logic [14:0] acc;
        acc = '0;
        for (int i = 0; i < 15; i++) begin
            if (((FB_W >> i) & 1) != 0) begin
                acc = acc + (row << i);
            end
        end
        return acc;
    endfunction

    state_e      state_q, state_d;
    logic [14:0] cnt_q, cnt_d;
    logic [11:0] color_q, color_d;
    logic        done_q, done_d;
    logic        rd_pend_q, rd_pend_d;
    logic [11:0] pix_reg_q, pix_reg_d;
    logic        valid_d1_q, valid_d1_d;
    logic        valid_d2_q, valid_d2_d;

    logic        display_slot;
    logic        cpu_in_range;
    logic [14:0] disp_addr;
    logic [14:0] cpu_addr;
    logic        unused_v_lsbs;

    // Only block coordinates address the RAM; the row's sub-block bits are irrelevant.
    assign unused_v_lsbs = ^v_addr[1:0];

    assign display_slot = vga_valid && (h_addr[1:0] == 2'b00);
    assign disp_addr    = mul_fb_w(15'(v_addr[9:2])) + 15'(h_addr[9:2]);
    assign cpu_addr     = mul_fb_w(15'(cpu_y)) + 15'(cpu_x);
    assign cpu_in_range = ({1'b0, cpu_x} < FB_W_9) && ({1'b0, cpu_y} < FB_H_8);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        color_d    = color_q;
        done_d     = 1'b0;
        cpu_ready  = 1'b0;
        ram_addr   = '0;
        ram_we     = 1'b0;
        ram_wdata  = '0;
        rd_pend_d  = display_slot;
        pix_reg_d  = rd_pend_q ? ram_rdata : pix_reg_q;
        valid_d1_d = vga_valid;
        valid_d2_d = valid_d1_q;

        // The start pulse is honoured even when it lands on a display slot.
        unique case (state_q)
            ST_IDLE: begin
                if (clr_start) begin
                    state_d = ST_FILL;
                    cnt_d   = '0;
                    color_d = clr_color;
                end
            end
            ST_FILL: begin
                if (!display_slot) begin
                    if (cnt_q == LAST_ADDR) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 15'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (display_slot) begin
            ram_addr = disp_addr;
        end else if (state_q == ST_FILL) begin
            ram_we    = 1'b1;
            ram_addr  = cnt_q;
            ram_wdata = color_q;
        end else if (!clr_start) begin
            cpu_ready = 1'b1;
            // Out-of-range blocks complete the handshake but never reach the RAM.
            if (cpu_valid && cpu_in_range) begin
                ram_we    = 1'b1;
                ram_addr  = cpu_addr;
                ram_wdata = cpu_color;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            color_q    <= '0;
            done_q     <= 1'b0;
            rd_pend_q  <= 1'b0;
            pix_reg_q  <= '0;
            valid_d1_q <= 1'b0;
            valid_d2_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop update from pre-edge values.
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            color_q    <= color_d;
            done_q     <= done_d;
            rd_pend_q  <= rd_pend_d;
            pix_reg_q  <= pix_reg_d;
            valid_d1_q <= valid_d1_d;
            valid_d2_q <= valid_d2_d;
        end
    end

    assign vga_data = valid_d2_q ? pix_reg_q : 12'h000;
    assign clr_busy = (state_q == ST_FILL);
    assign clr_done = done_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Self-checking bench for vga_fb_arbiter: synchronous-read RAM model, directed
// display/CPU/fill scenarios and randomized traffic against a framebuffer reference model.
module tb_vga_fb_arbiter;

    localparam int FB_W  = 160;
    localparam int FB_H  = 120;
    localparam int TOTAL = FB_W * FB_H;

    logic        clk;
    logic        rst;
    logic [9:0]  h_addr;
    logic [9:0]  v_addr;
    logic        vga_valid;
    logic [11:0] vga_data;
    logic        cpu_valid;
    logic        cpu_ready;
    logic [7:0]  cpu_x;
    logic [6:0]  cpu_y;
    logic [11:0] cpu_color;
    logic        clr_start;
    logic [11:0] clr_color;
    logic        clr_busy;
    logic        clr_done;
    logic [14:0] ram_addr;
    logic        ram_we;
    logic [11:0] ram_wdata;
    logic [11:0] ram_rdata;

    // Synchronous-read RAM model plus a preload port the bench uses during reset.
    logic [11:0] mem [0:32767] = '{default: 12'h000};
    logic        pre_we;
    logic [14:0] pre_addr;
    logic [11:0] pre_data;

    // Reference framebuffer contents and output-pipeline expectation.
    logic [11:0] ref_mem [0:32767] = '{default: 12'h000};
    logic [11:0] mdl_pix;
    logic [11:0] pipe1;
    logic [11:0] pipe2;

    int vectors;
    int miscompares;

    logic [11:0] obs_vga;
    logic        obs_ready;
    logic        obs_we;
    logic [14:0] obs_addr;

    vga_fb_arbiter #(.FB_W(FB_W), .FB_H(FB_H)) dut (
        .clk       (clk),
        .rst       (rst),
        .h_addr    (h_addr),
        .v_addr    (v_addr),
        .vga_valid (vga_valid),
        .vga_data  (vga_data),
        .cpu_valid (cpu_valid),
        .cpu_ready (cpu_ready),
        .cpu_x     (cpu_x),
        .cpu_y     (cpu_y),
        .cpu_color (cpu_color),
        .clr_start (clr_start),
        .clr_color (clr_color),
        .clr_busy  (clr_busy),
        .clr_done  (clr_done),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One idle-state cycle: inputs are already driven; sample at negedge, then advance.
    task automatic step();
        bit          slot;
        bit          exp_we;
        int          exp_addr;
        logic [11:0] exp_wd;
        @(negedge clk);
        obs_vga   = vga_data;
        obs_ready = cpu_ready;
        obs_we    = ram_we;
        obs_addr  = ram_addr;
        slot      = vga_valid && (h_addr % 4 == 0);
        exp_we    = 1'b0;
        exp_wd    = 12'h000;
        exp_addr  = -1;
        if (slot) begin
            exp_addr = (int'(v_addr) / 4) * FB_W + int'(h_addr) / 4;
        end else if (cpu_valid && int'(cpu_x) < FB_W && int'(cpu_y) < FB_H) begin
            exp_we   = 1'b1;
            exp_addr = int'(cpu_y) * FB_W + int'(cpu_x);
            exp_wd   = cpu_color;
        end
        check("cpu_ready", 32'(cpu_ready), 32'(!slot));
        check("ram_we", 32'(ram_we), 32'(exp_we));
        check("ram_wdata", 32'(ram_wdata), 32'(exp_wd));
        if (exp_addr >= 0) check("ram_addr", 32'(ram_addr), 32'(exp_addr));
        check("vga_data", 32'(vga_data), 32'(pipe2));
        if (slot) mdl_pix = ref_mem[exp_addr];
        if (exp_we) ref_mem[exp_addr] = exp_wd;
        pipe2 = pipe1;
        pipe1 = vga_valid ? mdl_pix : 12'h000;
        @(posedge clk);
        #1;
    endtask

    // Runs a fill from IDLE with video blanked. Returns at a negedge, either after the
    // abort point or a few cycles past clr_done; full runs are checked here.
    task automatic fill_run(input logic [11:0] col, input int inject_at, input int abort_at);
        int writes, seq_err, ready_hi, busy_lo, done_cnt, done_busy, done_at;
        int done_cyc, first_wcyc, last_wcyc;
        writes = 0; seq_err = 0; ready_hi = 0; busy_lo = 0;
        done_cnt = 0; done_busy = 0; done_at = -1; done_cyc = -1;
        first_wcyc = -1; last_wcyc = -1;
        vga_valid = 1'b0; clr_start = 1'b1; clr_color = col;
        cpu_valid = 1'b1; cpu_x = 8'd1; cpu_y = 7'd1; cpu_color = 12'hFFF;
        for (int cyc = 0; cyc < 25000; cyc++) begin
            @(negedge clk);
            if (clr_done) begin
                done_cnt++;
                if (clr_busy) done_busy++;
                if (done_at < 0) begin
                    done_at  = writes;
                    done_cyc = cyc;
                end
            end else if (done_cnt == 0) begin
                if (cpu_ready) ready_hi++;
                if (cyc >= 1 && writes < TOTAL && !clr_busy) busy_lo++;
            end
            if (ram_we) begin
                if (int'(ram_addr) != writes || ram_wdata !== col) seq_err++;
                if (first_wcyc < 0) first_wcyc = cyc;
                last_wcyc = cyc;
                if (writes < TOTAL) ref_mem[writes] = col;
                writes++;
            end
            if (abort_at >= 0 && writes == abort_at) break;
            if (done_cnt > 0 && cyc >= done_cyc + 2) break;
            @(posedge clk);
            #1;
            clr_start = (inject_at >= 0 && writes == inject_at);
            clr_color = 12'hABC;
            cpu_valid = (writes < TOTAL);
        end
        check("fill_seq_errors", 32'(seq_err), 32'd0);
        check("fill_first_write_cycle", 32'(first_wcyc), 32'd1);
        check("fill_ready_during_fill", 32'(ready_hi), 32'd0);
        check("fill_busy_low_during_fill", 32'(busy_lo), 32'd0);
        if (abort_at < 0) begin
            check("fill_write_count", 32'(writes), 32'(TOTAL));
            check("fill_consecutive", 32'(last_wcyc - first_wcyc), 32'(TOTAL - 1));
            check("fill_done_pulses", 32'(done_cnt), 32'd1);
            check("fill_busy_with_done", 32'(done_busy), 32'd0);
            check("fill_done_after_last", 32'(done_at), 32'(TOTAL));
            check("fill_busy_after", 32'(clr_busy), 32'd0);
        end else begin
            check("abort_write_count", 32'(writes), 32'(abort_at));
            check("abort_no_done", 32'(done_cnt), 32'd0);
        end
    endtask

    initial begin
        int w325, accept_h, done_hi;
        vectors = 0; miscompares = 0;
        mdl_pix = 12'h000; pipe1 = 12'h000; pipe2 = 12'h000;
        rst = 1'b1;
        h_addr = '0; v_addr = '0; vga_valid = 1'b0;
        cpu_valid = 1'b0; cpu_x = '0; cpu_y = '0; cpu_color = '0;
        clr_start = 1'b0; clr_color = '0;
        pre_we = 1'b1; pre_addr = 15'd0; pre_data = 12'hF00;
        ref_mem[0] = 12'hF00;
        ref_mem[1] = 12'h0F0;

        // Reset: preload two blocks while checking the reset outputs.
        @(posedge clk); #1;
        pre_addr = 15'd1; pre_data = 12'h0F0;
        @(posedge clk); #1;
        pre_we = 1'b0;
        @(negedge clk);
        check("rst_vga_data", 32'(vga_data), 32'd0);
        check("rst_clr_busy", 32'(clr_busy), 32'd0);
        check("rst_clr_done", 32'(clr_done), 32'd0);
        check("rst_ram_we", 32'(ram_we), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // First display read after reset: F00 x4 then 0F0 x4, two cycles late.
        for (int i = 0; i < 10; i++) begin
            vga_valid = (i < 8);
            h_addr    = 10'(i < 8 ? i : 0);
            v_addr    = 10'd0;
            step();
            if (i >= 2) check("first_line_pixel", 32'(obs_vga), 32'(i < 6 ? 12'hF00 : 12'h0F0));
        end

        // CPU write held through active video: accepted only off the display slot.
        w325 = 0; accept_h = -1;
        cpu_x = 8'd5; cpu_y = 7'd2; cpu_color = 12'h123;
        for (int i = 0; i < 8; i++) begin
            vga_valid = 1'b1;
            h_addr    = 10'(i);
            v_addr    = 10'd8;
            cpu_valid = (accept_h < 0);
            step();
            if (obs_we && obs_addr == 15'd325) w325++;
            if (cpu_valid && obs_ready && accept_h < 0) accept_h = i;
        end
        check("cpu_accept_h", 32'(accept_h), 32'd1);
        check("cpu_writes_325", 32'(w325), 32'd1);

        // Out-of-range and corner-range CPU writes.
        vga_valid = 1'b0; cpu_valid = 1'b1;
        cpu_x = 8'd200; cpu_y = 7'd3; cpu_color = 12'h777;
        step();
        check("oob_x_ready", 32'(obs_ready), 32'd1);
        check("oob_x_we", 32'(obs_we), 32'd0);
        cpu_x = 8'd10; cpu_y = 7'd120;
        step();
        check("oob_y_we", 32'(obs_we), 32'd0);
        cpu_x = 8'd159; cpu_y = 7'd119; cpu_color = 12'h9A5;
        step();
        check("last_block_addr", 32'(obs_addr), 32'(TOTAL - 1));

        // Randomized display scanning mixed with CPU traffic.
        for (int i = 0; i < 1500; i++) begin
            vga_valid = ($urandom % 4) != 0;
            h_addr    = ($urandom % 2) != 0 ? 10'((int'(h_addr) + 1) % 640) : 10'($urandom_range(0, 639));
            v_addr    = 10'($urandom_range(0, 479));
            cpu_valid = ($urandom % 2) != 0;
            cpu_x     = 8'($urandom_range(0, 199));
            cpu_y     = 7'($urandom_range(0, 127));
            cpu_color = 12'($urandom);
            step();
        end
        vga_valid = 1'b0; cpu_valid = 1'b0;
        step();
        step();

        // Fill aborted by reset after 100 writes.
        fill_run(12'h0F0, -1, 100);
        @(posedge clk); #1;
        rst = 1'b1; cpu_valid = 1'b0; clr_start = 1'b0;
        #1;
        check("abort_ram_we", 32'(ram_we), 32'd0);
        check("abort_clr_busy", 32'(clr_busy), 32'd0);
        check("abort_clr_done", 32'(clr_done), 32'd0);
        check("abort_vga_data", 32'(vga_data), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        mdl_pix = 12'h000; pipe1 = 12'h000; pipe2 = 12'h000;
        done_hi = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (clr_done || clr_busy || ram_we) done_hi++;
            @(posedge clk); #1;
        end
        check("abort_quiet_after", 32'(done_hi), 32'd0);

        // Full fill restarts from address 0; then a fill with an ignored second start.
        fill_run(12'h00F, -1, -1);
        @(posedge clk); #1;
        fill_run(12'h5A5, 50, -1);
        @(posedge clk); #1;
        clr_start = 1'b0; cpu_valid = 1'b0; vga_valid = 1'b0;
        step();
        step();

        // Display and CPU traffic over the filled framebuffer.
        for (int i = 0; i < 200; i++) begin
            vga_valid = ($urandom % 3) != 0;
            h_addr    = 10'($urandom_range(0, 639));
            v_addr    = 10'($urandom_range(0, 479));
            cpu_valid = ($urandom % 2) != 0;
            cpu_x     = 8'($urandom_range(0, 159));
            cpu_y     = 7'($urandom_range(0, 119));
            cpu_color = 12'($urandom);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
